// File: rtl/booth_mult_4bit.sv
// Sequential signed 4x4 radix-2 Booth multiplier with a start/busy/done handshake.
// One addsub_4bit performs every partial-product step; its ovfl output restores the true sign during the shift.

module addsub_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       sub,
  output logic [3:0] sum,
  output logic       ovfl
);

  logic [3:0] b_x;
  logic [4:0] full;

  // Two's-complement add/subtract with signed overflow detect
  always_comb begin
    b_x  = b ^ {4{sub}};
    full = {1'b0, a} + {1'b0, b_x} + {4'b0000, sub};
    sum  = full[3:0];
    ovfl = (a[3] == b_x[3]) & (sum[3] != a[3]);
  end

endmodule

module booth_mult_4bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] product,
  output logic       busy,
  output logic       done
);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] u_q, u_d;
  logic [3:0] q_q, q_d;
  logic       q1_q, q1_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] product_q, product_d;
  logic       done_q, done_d;

  logic       as_sub;
  logic [3:0] as_sum;
  logic       as_ovfl;
  logic [3:0] step_sum;
  logic       step_sign;
  logic [3:0] u_sh;
  logic [3:0] q_sh;

  addsub_4bit u_addsub (
    .a    (u_q),
    .b    (m_q),
    .sub  (as_sub),
    .sum  (as_sum),
    .ovfl (as_ovfl)
  );

  // Booth step: pick add/sub/pass and form the sign-corrected arithmetic shift
  always_comb begin
    as_sub    = 1'b0;
    step_sum  = u_q;
    step_sign = u_q[3];
    case ({q_q[0], q1_q})
      2'b01: begin
        as_sub    = 1'b0;
        step_sum  = as_sum;
        step_sign = as_sum[3] ^ as_ovfl;
      end
      2'b10: begin
        as_sub    = 1'b1;
        step_sum  = as_sum;
        step_sign = as_sum[3] ^ as_ovfl;
      end
      default: begin
        as_sub    = 1'b0;
        step_sum  = u_q;
        step_sign = u_q[3];
      end
    endcase
    u_sh = {step_sign, step_sum[3:1]};
    q_sh = {step_sum[0], q_q[3:1]};
  end

  // Next-state logic and datapath register updates
  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    u_d       = u_q;
    q_d       = q_q;
    q1_d      = q1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = A;
          u_d     = 4'h0;
          q_d     = B;
          q1_d    = 1'b0;
          cnt_d   = 2'd0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        u_d   = u_sh;
        q_d   = q_sh;
        q1_d  = q_q[0];
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          product_d = {u_sh, q_sh};
          done_d    = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = CALC;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= 4'h0;
      u_q       <= 4'h0;
      q_q       <= 4'h0;
      q1_q      <= 1'b0;
      cnt_q     <= 2'd0;
      product_q <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      u_q       <= u_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  // Handshake outputs
  always_comb begin
    busy    = (state_q == CALC);
    product = product_q;
    done    = done_q;
  end

endmodule

// File: tb/tb_booth_mult_4bit.sv
// Self-checking bench for booth_mult_4bit: directed corner cases, handshake timing and random pairs
// compared against a plain signed-multiply reference.

module tb_booth_mult_4bit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] A = 4'h0;
  logic [3:0] B = 4'h0;
  logic [7:0] product;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  booth_mult_4bit dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .A       (A),
    .B       (B),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ref_mul(input logic signed [3:0] a, input logic signed [3:0] b);
    int r;
    r = int'(a) * int'(b);
    return r[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one multiply and wait (bounded) for done; edges = edges after acceptance
  task automatic do_mult(input logic [3:0] a, input logic [3:0] b,
                         output logic [7:0] p, output int edges);
    A = a; B = b; start = 1'b1;
    tick();
    start = 1'b0;
    edges = 0;
    while (!done && edges < 20) begin
      tick();
      edges++;
    end
    p = product;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if (product !== 8'h00 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: product=%h done=%b busy=%b, required 00/0/0", product, done, busy);
    end
  endtask

  task automatic test_latency();
    int busy_cnt = 0;
    A = 4'd3; B = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (busy) busy_cnt++;
      tick();
      if (i < 4) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL latency_early_done: edge k+%0d done=%b, required 0", i, done);
        end
      end else begin
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || product !== 8'h06) begin
          errors++;
          $display("FAIL latency_done: done=%b busy=%b product=%h, required 1/0/06", done, busy, product);
        end
      end
    end
    checks++;
    if (busy_cnt != 4) begin
      errors++;
      $display("FAIL busy_width: busy cycles=%0d, required 4", busy_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0 || product !== 8'h06) begin
      errors++;
      $display("FAIL done_pulse: done=%b product=%h, required 0/06", done, product);
    end
  endtask

  task automatic test_corners();
    logic [3:0] av [6] = '{4'h8, 4'h8, 4'h7, 4'h0, 4'hF, 4'h7};
    logic [3:0] bv [6] = '{4'h8, 4'h7, 4'hF, 4'hB, 4'hF, 4'h7};
    logic [7:0] ev [6] = '{8'h40, 8'hC8, 8'hF9, 8'h00, 8'h01, 8'h31};
    logic [7:0] p;
    int edges;
    for (int i = 0; i < 6; i++) begin
      do_mult(av[i], bv[i], p, edges);
      checks++;
      if (edges != 4 || p !== ev[i]) begin
        errors++;
        $display("FAIL corner %0d: A=%h B=%h product=%h edges=%0d, required %h edges=4",
                 i, av[i], bv[i], p, edges, ev[i]);
      end
      tick();
    end
  endtask

  task automatic test_ignore_start();
    int extra = 0;
    A = 4'd3; B = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 4'd7; B = 4'd7; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || product !== 8'h0F) begin
      errors++;
      $display("FAIL ignore_start: done=%b product=%h, required 1/0F", done, product);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL ignore_start_queued: extra activity cycles=%0d, required 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    logic [7:0] p;
    int edges;
    int seen = 0;
    A = 4'd5; B = 4'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || product !== 8'h00 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b product=%h done=%b, required 0/00/0", busy, product, done);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_abort_done: done pulses=%0d, required 0", seen);
    end
    do_mult(4'd5, 4'd5, p, edges);
    checks++;
    if (p !== 8'h19 || edges != 4) begin
      errors++;
      $display("FAIL after_abort: product=%h edges=%0d, required 19 edges=4", p, edges);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] av [3] = '{4'd2, 4'hD, 4'h8};
    logic [3:0] bv [3] = '{4'd6, 4'd4, 4'hD};
    int edges;
    A = av[0]; B = bv[0]; start = 1'b1;
    tick();
    for (int op = 0; op < 3; op++) begin
      edges = 0;
      while (!done && edges < 20) begin
        tick();
        edges++;
      end
      checks++;
      if (edges != 4 || product !== ref_mul(av[op], bv[op])) begin
        errors++;
        $display("FAIL back_to_back %0d: product=%h edges=%0d, required %h edges=4",
                 op, product, edges, ref_mul(av[op], bv[op]));
      end
      if (op < 2) begin
        A = av[op + 1]; B = bv[op + 1];
        tick();
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL back_to_back_accept %0d: busy=%b, required 1", op, busy);
        end
      end else begin
        start = 1'b0;
      end
    end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] a, b;
    logic [7:0] p;
    int edges;
    for (int i = 0; i < 256; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      do_mult(a, b, p, edges);
      checks++;
      if (edges != 4 || p !== ref_mul(a, b)) begin
        errors++;
        $display("FAIL random %0d: A=%h B=%h product=%h edges=%0d, required %h edges=4",
                 i, a, b, p, edges, ref_mul(a, b));
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_corners();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
